// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts and constants for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int unsigned EM_W = 195;
    localparam int unsigned MW_W = 159;
    localparam int unsigned MD_W = 117;

    // res_from_mem bit positions
    localparam int unsigned LD_W = 3;
    localparam int unsigned LD_U = 2;
    localparam int unsigned LD_H = 1;
    localparam int unsigned LD_B = 0;

    localparam logic [7:0] ECODE_INT = 8'h00;
    localparam logic [7:0] ECODE_ADE = 8'h08;
    localparam logic [7:0] ECODE_ALE = 8'h09;
    localparam logic [7:0] ECODE_SYS = 8'h0b;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rf_wdata;
        logic        gr_we;
        logic [4:0]  dest;
        logic [3:0]  res_from_mem;
        logic [31:0] addr;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } em_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] final_result;
        logic        gr_we;
        logic [4:0]  dest;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } mw_bus_t;

    typedef struct packed {
        logic        ld_pending;
        logic [4:0]  dest_masked;
        logic [31:0] final_result;
        logic        csr_we_v;
        logic [13:0] csr_addr;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } md_bus_t;

    typedef enum logic {RbufIdle, RbufHeld} rbuf_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed word/half/byte out of the raw SRAM word and extends it.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] ld_raw,
    input  logic [1:0]  addr,
    input  logic [3:0]  res_from_mem,
    output logic [31:0] result
);

    logic [31:0] half_sh;
    logic [31:0] byte_sh;

    always_comb begin
        half_sh = ld_raw >> {addr[1], 4'b0000};
        byte_sh = ld_raw >> {addr, 3'b000};
        result  = ld_raw;
        if (res_from_mem[LD_W]) begin
            result = ld_raw;
        end else if (res_from_mem[LD_H]) begin
            result = res_from_mem[LD_U] ? {16'b0, half_sh[15:0]}
                                        : {{16{half_sh[15]}}, half_sh[15:0]};
        end else if (res_from_mem[LD_B]) begin
            result = res_from_mem[LD_U] ? {24'b0, byte_sh[7:0]}
                                        : {{24{byte_sh[7]}}, byte_sh[7:0]};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the E->M bus, holds load data across W stalls,
// aligns loads, and drives the M->W and M->D forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            em_valid,
    input  logic [EM_W-1:0] em_bus,
    output logic            m_allowin,
    input  logic            w_allowin,
    output logic            mw_valid,
    output logic [MW_W-1:0] mw_bus,
    output logic [MD_W-1:0] md_for_bus,
    input  logic            ex_en,
    input  logic [31:0]     data_sram_rdata
);

    em_bus_t     em_in;
    em_bus_t     em_q;
    logic        m_valid_q;
    logic        entry_q;
    logic        ex_flag_q;
    logic [31:0] rbuf_q, rbuf_d;
    rbuf_state_e state_q, state_d;

    logic        ex_m;
    logic [31:0] ld_raw;
    logic [31:0] aligned;
    logic [31:0] final_result;
    mw_bus_t     mw;
    md_bus_t     md;
    logic        unused_addr;

    assign em_in     = em_bus;
    assign ex_m      = m_valid_q & em_q.ex;
    assign m_allowin = !m_valid_q | w_allowin;
    assign mw_valid  = m_valid_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_valid_q <= 1'b0;
            em_q      <= '0;
            entry_q   <= 1'b0;
            ex_flag_q <= 1'b0;
            state_q   <= RbufIdle;
            rbuf_q    <= '0;
        end else begin
            // Younger instructions are dropped while an exception is outstanding.
            if (m_allowin) begin
                m_valid_q <= em_valid & ((!ex_flag_q & !ex_m) | ex_en);
            end else if (ex_en) begin
                m_valid_q <= 1'b0;
            end
            if (em_valid & m_allowin) begin
                em_q <= em_in;
            end
            entry_q <= m_allowin;
            if (ex_en) begin
                ex_flag_q <= 1'b0;
            end else if (ex_m) begin
                ex_flag_q <= 1'b1;
            end
            state_q <= state_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Once M stalls, E may reissue a read and overwrite the SRAM output, so keep the first beat.
    always_comb begin
        state_d = state_q;
        rbuf_d  = rbuf_q;
        unique case (state_q)
            RbufIdle: begin
                if (entry_q & m_valid_q & !w_allowin & !ex_en) begin
                    state_d = RbufHeld;
                    rbuf_d  = data_sram_rdata;
                end
            end
            RbufHeld: begin
                if (m_allowin | ex_en) begin
                    state_d = RbufIdle;
                end
            end
            default: state_d = RbufIdle;
        endcase
    end

    assign ld_raw = (state_q == RbufHeld) ? rbuf_q : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .ld_raw       (ld_raw),
        .addr         (em_q.addr[1:0]),
        .res_from_mem (em_q.res_from_mem),
        .result       (aligned)
    );

    assign final_result = |em_q.res_from_mem ? aligned : em_q.rf_wdata;
    assign unused_addr  = ^em_q.addr[31:2];

    always_comb begin
        mw              = '0;
        mw.pc           = em_q.pc;
        mw.final_result = final_result;
        mw.gr_we        = em_q.gr_we & !ex_m;
        mw.dest         = em_q.dest;
        mw.ex           = em_q.ex;
        mw.ecode        = em_q.ecode;
        mw.esubcode     = em_q.esubcode;
        mw.csr_addr     = em_q.csr_addr;
        mw.csr_we       = em_q.csr_we & !ex_m;
        mw.csr_wmask    = em_q.csr_wmask;
        mw.csr_wdata    = em_q.csr_wdata;

        md              = '0;
        md.ld_pending   = 1'b0;
        md.dest_masked  = em_q.dest & {5{m_valid_q & em_q.gr_we & !ex_m}};
        md.final_result = final_result;
        md.csr_we_v     = m_valid_q & em_q.csr_we & !ex_m;
        md.csr_addr     = em_q.csr_addr;
        md.csr_wmask    = em_q.csr_wmask;
        md.csr_wdata    = em_q.csr_wdata;
    end

    assign mw_bus     = mw;
    assign md_for_bus = md;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random traffic against a
// transaction-level model of the stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic            clk;
    logic            rstn;
    logic            em_valid;
    logic [EM_W-1:0] em_bus;
    logic            m_allowin;
    logic            w_allowin;
    logic            mw_valid;
    logic [MW_W-1:0] mw_bus;
    logic [MD_W-1:0] md_for_bus;
    logic            ex_en;
    logic [31:0]     data_sram_rdata;

    mw_bus_t mw_s;
    md_bus_t md_s;
    assign mw_s = mw_bus;
    assign md_s = md_for_bus;

    int errs;
    int checks;

    // Model state: the instruction sitting in M and the load word it saw on its first cycle.
    bit          mv;
    em_bus_t     mpay;
    bit          mexf;
    bit          mfirst;
    logic [31:0] mheld;

    mem_stage dut (
        .clk             (clk),
        .rstn            (rstn),
        .em_valid        (em_valid),
        .em_bus          (em_bus),
        .m_allowin       (m_allowin),
        .w_allowin       (w_allowin),
        .mw_valid        (mw_valid),
        .mw_bus          (mw_bus),
        .md_for_bus      (md_for_bus),
        .ex_en           (ex_en),
        .data_sram_rdata (data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(logic [31:0] raw, logic [1:0] a, logic [3:0] rfm);
        logic [31:0] v;
        if (rfm[3]) return raw;
        if (rfm[1]) begin
            v = (raw >> (a[1] * 16)) & 32'hFFFF;
            if (!rfm[2] && v >= 32'h8000) v = v - 32'h10000;
        end else if (rfm[0]) begin
            v = (raw >> (a * 8)) & 32'hFF;
            if (!rfm[2] && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    function automatic em_bus_t mk(logic [31:0] wdata, logic gr_we, logic [4:0] dest,
                                   logic [3:0] rfm, logic [31:0] addr, logic ex,
                                   logic [7:0] ecode, logic csr_we);
        em_bus_t b;
        b              = '0;
        b.pc           = $urandom;
        b.rf_wdata     = wdata;
        b.gr_we        = gr_we;
        b.dest         = dest;
        b.res_from_mem = rfm;
        b.addr         = addr;
        b.ex           = ex;
        b.ecode        = ecode;
        b.esubcode     = ex & (ecode == ECODE_ADE);
        b.csr_addr     = 14'($urandom);
        b.csr_we       = csr_we;
        b.csr_wmask    = $urandom;
        b.csr_wdata    = $urandom;
        return b;
    endfunction

    task automatic drive(input logic ev, input em_bus_t bus, input logic wa, input logic xe,
                         input logic [31:0] rd, input logic rs);
        em_valid        = ev;
        em_bus          = bus;
        w_allowin       = wa;
        ex_en           = xe;
        data_sram_rdata = rd;
        rstn            = rs;
        #1;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic check_model();
        logic        exm;
        logic [31:0] raw;
        logic [31:0] fr;
        mw_bus_t     emw;
        md_bus_t     emd;
        exm = mv & mpay.ex;
        raw = (mv && !mfirst) ? mheld : data_sram_rdata;
        fr  = (mpay.res_from_mem != 0) ? ref_load(raw, mpay.addr[1:0], mpay.res_from_mem)
                                       : mpay.rf_wdata;
        emw              = '0;
        emw.pc           = mpay.pc;
        emw.final_result = fr;
        emw.gr_we        = mpay.gr_we && !exm;
        emw.dest         = mpay.dest;
        emw.ex           = mpay.ex;
        emw.ecode        = mpay.ecode;
        emw.esubcode     = mpay.esubcode;
        emw.csr_addr     = mpay.csr_addr;
        emw.csr_we       = mpay.csr_we && !exm;
        emw.csr_wmask    = mpay.csr_wmask;
        emw.csr_wdata    = mpay.csr_wdata;
        emd              = '0;
        emd.dest_masked  = (mv && mpay.gr_we && !exm) ? mpay.dest : 5'd0;
        emd.final_result = fr;
        emd.csr_we_v     = mv && mpay.csr_we && !exm;
        emd.csr_addr     = mpay.csr_addr;
        emd.csr_wmask    = mpay.csr_wmask;
        emd.csr_wdata    = mpay.csr_wdata;
        check("mw_valid", mw_valid, mv);
        check("m_allowin", m_allowin, !mv || w_allowin);
        check("mw_bus", mw_bus, emw);
        check("md_for_bus", md_for_bus, emd);
    endtask

    task automatic tick();
        logic    allow;
        logic    exm;
        logic    nexf;
        @(posedge clk);
        if (!rstn) begin
            mv = 0; mpay = '0; mexf = 0; mfirst = 0;
        end else begin
            allow = !mv || w_allowin;
            exm   = mv && mpay.ex;
            if (mv && mfirst && !w_allowin && !ex_en) mheld = data_sram_rdata;
            nexf  = ex_en ? 1'b0 : (exm ? 1'b1 : mexf);
            if (allow) begin
                mv = em_valid && ((!mexf && !exm) || ex_en);
                if (em_valid) mpay = em_bus;
                mfirst = 1;
            end else begin
                if (ex_en) mv = 0;
                mfirst = 0;
            end
            mexf = nexf;
        end
        #1;
    endtask

    em_bus_t ins;
    em_bus_t nop_bus;
    logic [3:0]  rfm_tab [6];
    logic [31:0] rd_tab  [3];
    logic [31:0] exp_tab [3];
    em_bus_t     ld_tab  [3];

    initial begin
        errs = 0; checks = 0; nop_bus = '0;
        mv = 0; mpay = '0; mexf = 0; mfirst = 0; mheld = '0;
        drive(0, nop_bus, 1, 0, 0, 0);
        tick(); tick();

        // Reset state
        drive(0, nop_bus, 0, 0, 0, 1);
        check_model();
        check("rst_mw_valid", mw_valid, 0);
        check("rst_allowin", m_allowin, 1);
        check("rst_dest", md_s.dest_masked, 0);
        check("rst_csr_we_v", md_s.csr_we_v, 0);

        // 1: ld.w no stall
        ins = mk(0, 1, 5'd3, 4'b1000, 32'h1000, 0, 0, 0);
        drive(1, ins, 1, 0, 0, 1); check_model(); tick();
        drive(0, nop_bus, 1, 0, 32'h8899AABB, 1); check_model();
        check("ldw_valid", mw_valid, 1);
        check("ldw_result", mw_s.final_result, 32'h8899AABB);
        check("ldw_fwd_dest", md_s.dest_masked, 5'd3);
        check("ldw_fwd_data", md_s.final_result, 32'h8899AABB);
        tick();

        // 2: byte/half alignment and extension
        ld_tab[0] = mk(0, 1, 5'd4, 4'b0001, 32'h2003, 0, 0, 0);
        ld_tab[1] = mk(0, 1, 5'd4, 4'b0101, 32'h2003, 0, 0, 0);
        ld_tab[2] = mk(0, 1, 5'd4, 4'b0010, 32'h2002, 0, 0, 0);
        rd_tab  = '{32'h80123456, 32'h80123456, 32'h7FFF0000};
        exp_tab = '{32'hFFFFFF80, 32'h00000080, 32'h00007FFF};
        for (int i = 0; i < 3; i++) begin
            drive(1, ld_tab[i], 1, 0, 0, 1); check_model(); tick();
            drive(0, nop_bus, 1, 0, rd_tab[i], 1); check_model();
            check($sformatf("align_%0d", i), mw_s.final_result, exp_tab[i]);
            tick();
        end

        // 3: stalled load keeps the first captured word
        ins = mk(0, 1, 5'd7, 4'b1000, 32'h3000, 0, 0, 0);
        drive(1, ins, 1, 0, 0, 1); check_model(); tick();
        drive(0, nop_bus, 0, 0, 32'h11223344, 1); check_model(); tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, nop_bus, 0, 0, 32'hDEADBEEF, 1); check_model();
            check("stall_allowin", m_allowin, 0);
            tick();
        end
        drive(0, nop_bus, 1, 0, 32'hDEADBEEF, 1); check_model();
        check("stall_result", mw_s.final_result, 32'h11223344);
        tick();

        // 4: exception masks writes and blocks younger instructions until ex_en
        ins = mk(32'h55, 1, 5'd9, 4'b0000, 32'h4001, 1, ECODE_ADE, 1);
        drive(1, ins, 1, 0, 0, 1); check_model(); tick();
        ins = mk(32'h66, 1, 5'd10, 4'b0000, 0, 0, 0, 1);
        drive(1, ins, 1, 0, 0, 1); check_model();
        check("ex_flag", mw_s.ex, 1);
        check("ex_ecode", mw_s.ecode, ECODE_ADE);
        check("ex_gr_we", mw_s.gr_we, 0);
        check("ex_csr_we_v", md_s.csr_we_v, 0);
        tick();
        drive(1, ins, 1, 0, 0, 1); check_model();
        check("ex_drop", mw_valid, 0);
        tick();
        drive(0, nop_bus, 1, 1, 0, 1); check_model(); tick();
        drive(1, ins, 1, 0, 0, 1); check_model(); tick();
        drive(0, nop_bus, 1, 0, 0, 1); check_model();
        check("ex_resume", mw_valid, 1);
        tick();

        // 5: ALU result forwarding
        ins = mk(32'h12345678, 1, 5'd5, 4'b0000, 0, 0, 0, 0);
        drive(1, ins, 1, 0, 32'hFFFFFFFF, 1); check_model(); tick();
        drive(0, nop_bus, 1, 0, 32'hFFFFFFFF, 1); check_model();
        check("alu_result", mw_s.final_result, 32'h12345678);
        check("alu_dest", md_s.dest_masked, 5'd5);
        tick();
        drive(0, nop_bus, 1, 0, 0, 1); check_model();
        check("idle_dest", md_s.dest_masked, 0);
        tick();

        // 6: reset while a stalled load holds its buffer
        ins = mk(0, 1, 5'd6, 4'b1000, 32'h5000, 0, 0, 0);
        drive(1, ins, 1, 0, 0, 1); check_model(); tick();
        drive(0, nop_bus, 0, 0, 32'hAAAA5555, 1); check_model(); tick();
        drive(0, nop_bus, 0, 0, 32'h0, 0); tick();
        drive(0, nop_bus, 0, 0, 32'h0, 1); check_model();
        check("rst_mid_valid", mw_valid, 0);
        check("rst_mid_allowin", m_allowin, 1);
        tick();
        drive(1, ins, 1, 0, 0, 1); check_model(); tick();
        drive(0, nop_bus, 1, 0, 32'hCAFEF00D, 1); check_model();
        check("rst_mid_live", mw_s.final_result, 32'hCAFEF00D);
        tick();

        // Random traffic
        rfm_tab = '{4'b0000, 4'b1000, 4'b0010, 4'b0110, 4'b0001, 4'b0101};
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  r;
            logic [31:0] a;
            r = rfm_tab[$urandom_range(5)];
            a = $urandom;
            if (r[3]) a[1:0] = 2'b00;
            else if (r[1]) a[0] = 1'b0;
            ins = mk($urandom, 1'($urandom), 5'($urandom), r, a,
                     $urandom_range(15) == 0, 8'($urandom), 1'($urandom));
            drive($urandom_range(9) < 7, ins, $urandom_range(9) < 6, $urandom_range(11) == 0,
                  $urandom, $urandom_range(199) != 0);
            check_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
